// File: rtl/input_debouncer_pkg.sv
// Shared types and sizing helpers for the input debouncer.
package input_debouncer_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Width of the qualification counter; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between an input debouncer and whoever drives/observes it.
interface input_debouncer_if #(
   parameter int GLITCH_W = 8
);
   logic                data_in;
   logic                glitch_clr;
   logic                data_out;
   logic                rise_pulse;
   logic                fall_pulse;
   logic                busy;
   logic [GLITCH_W-1:0] glitch_count;

   modport master (
      output data_in, glitch_clr,
      input  data_out, rise_pulse, fall_pulse, busy, glitch_count
   );

   modport slave (
      input  data_in, glitch_clr,
      output data_out, rise_pulse, fall_pulse, busy, glitch_count
   );
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Plain N-flop synchroniser; no logic between the flops so the chain can be
// recognised and constrained as a metastability path.
module sync_chain #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the raw input through the chain; reset preloads the idle level.
   always_ff @(posedge clk) begin
      if (reset) ff <= {STAGES{RESET_LEVEL}};
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer: synchronise, qualify a level change over DEBOUNCE_CYCLES samples,
// emit a clean level plus edge pulses and count rejected candidates.
//
//   state   | meaning
//   STABLE  | synchronised input agrees with data_out
//   PENDING | input differs from data_out, counting consecutive samples
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter int   GLITCH_W        = 8
) (
   input  logic            clk,
   input  logic            reset,
   input_debouncer_if.slave bus
);

   localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GC_MAX  = '1;

   logic                s;
   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                level;
   logic                rise_q;
   logic                fall_q;
   logic [GLITCH_W-1:0] gc;
   logic                glitch;

   sync_chain #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.data_in),
      .q     (s)
   );

   // A candidate that falls back to the current level before qualifying.
   assign glitch = (state == PENDING) && (s == level);

   // Qualification FSM, output level/pulses and saturating glitch counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= STABLE;
         cnt    <= '0;
         level  <= RESET_LEVEL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         gc     <= '0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state)
            STABLE: begin
               if (s != level) begin
                  state <= PENDING;
                  cnt   <= CNT_W'(1);
               end
            end
            PENDING: begin
               if (s == level) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  level  <= s;
                  rise_q <= s;
                  fall_q <= ~s;
                  state  <= STABLE;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
         // Clear wins over a coincident glitch.
         if (bus.glitch_clr)              gc <= '0;
         else if (glitch && gc != GC_MAX) gc <= gc + GLITCH_W'(1);
      end
   end

   assign bus.data_out     = level;
   assign bus.rise_pulse   = rise_q;
   assign bus.fall_pulse   = fall_q;
   assign bus.busy         = (state == PENDING);
   assign bus.glitch_count = gc;

endmodule
